// File: rtl/regfile_n.sv
// Parameterised register file with one write port and two combinational read ports.
// Optional write-through forwarding, optional hardwired-zero register 0, and per-register written flags.
module regfile_n #(
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 8,
  parameter int AW       = 3,
  parameter bit BYPASS   = 1'b1,
  parameter bit ZERO_REG = 1'b0
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic             Rin,
  input  logic [AW-1:0]    WAddr,
  input  logic [WIDTH-1:0] R,
  input  logic             set_0,
  input  logic [AW-1:0]    RAddrA,
  input  logic [AW-1:0]    RAddrB,
  output logic [WIDTH-1:0] QA,
  output logic [WIDTH-1:0] QB,
  output logic [DEPTH-1:0] Written
);

  localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];

  logic [WIDTH-1:0] regs_q [DEPTH];
  logic [WIDTH-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0] written_q;
  logic [DEPTH-1:0] written_d;
  logic             wr_en_s;
  logic [WIDTH-1:0] rd_a_s;
  logic [WIDTH-1:0] rd_b_s;

  function automatic logic addr_ok(input logic [AW-1:0] addr);
    return ({1'b0, addr} < DEPTH_C);
  endfunction

  function automatic logic is_zero_reg(input logic [AW-1:0] addr);
    return ZERO_REG && (addr == {AW{1'b0}});
  endfunction

  // A write is effective only when not clearing, in range and not aimed at a hardwired-zero register 0.
  assign wr_en_s = Rin && !set_0 && addr_ok(WAddr) && !is_zero_reg(WAddr);

  // Next-state: synchronous clear wins over a write.
  always_comb begin
    regs_d    = regs_q;
    written_d = written_q;
    if (set_0) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_d[i] = {WIDTH{1'b0}};
      end
      written_d = {DEPTH{1'b0}};
    end else if (wr_en_s) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (WAddr == i[AW-1:0]) begin
          regs_d[i]    = R;
          written_d[i] = 1'b1;
        end else begin
          regs_d[i]    = regs_q[i];
          written_d[i] = written_q[i];
        end
      end
    end else begin
      regs_d    = regs_q;
      written_d = written_q;
    end
  end

  // State registers with immediate clear on reset.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= {WIDTH{1'b0}};
      end
      written_q <= {DEPTH{1'b0}};
    end else begin
      regs_q    <= regs_d;
      written_q <= written_d;
    end
  end

  // Stored-value read muxes; addresses beyond DEPTH match no entry and yield zero.
  always_comb begin
    rd_a_s = {WIDTH{1'b0}};
    rd_b_s = {WIDTH{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      rd_a_s = rd_a_s | ((RAddrA == i[AW-1:0]) ? regs_q[i] : {WIDTH{1'b0}});
      rd_b_s = rd_b_s | ((RAddrB == i[AW-1:0]) ? regs_q[i] : {WIDTH{1'b0}});
    end
  end

  // Read port A: forced zero, forwarded write data, or stored value.
  always_comb begin
    QA = rd_a_s;
    if (is_zero_reg(RAddrA)) begin
      QA = {WIDTH{1'b0}};
    end else if (BYPASS && wr_en_s && (RAddrA == WAddr)) begin
      QA = R;
    end else begin
      QA = rd_a_s;
    end
  end

  // Read port B: same selection as port A.
  always_comb begin
    QB = rd_b_s;
    if (is_zero_reg(RAddrB)) begin
      QB = {WIDTH{1'b0}};
    end else if (BYPASS && wr_en_s && (RAddrB == WAddr)) begin
      QB = R;
    end else begin
      QB = rd_b_s;
    end
  end

  assign Written = written_q;

endmodule

// File: tb/tb_regfile_n.sv
// Scoreboard bench for regfile_n: three instances (default, no-forwarding, DEPTH=6 with zero register)
// share stimulus; expectations are queued and a monitor compares them on each sample strobe.
module tb_regfile_n;

  logic        Clock = 1'b0;
  logic        Resetn;
  logic        Rin;
  logic        set_0;
  logic [2:0]  WAddr;
  logic [2:0]  RAddrA;
  logic [2:0]  RAddrB;
  logic [15:0] R;
  logic [15:0] qa0, qb0, qa1, qb1, qa2, qb2;
  logic [7:0]  w0, w1;
  logic [5:0]  w2;
  logic        strobe = 1'b0;

  typedef struct {
    string       name;
    int          d;
    logic [15:0] qa;
    logic [15:0] qb;
    logic [7:0]  w;
  } exp_t;

  exp_t sb_q[$];
  int   compared   = 0;
  int   mismatched = 0;

  always #5 Clock = ~Clock;

  regfile_n dut0 (.Clock(Clock), .Resetn(Resetn), .Rin(Rin), .WAddr(WAddr), .R(R), .set_0(set_0),
                  .RAddrA(RAddrA), .RAddrB(RAddrB), .QA(qa0), .QB(qb0), .Written(w0));

  regfile_n #(.BYPASS(1'b0)) dut1 (.Clock(Clock), .Resetn(Resetn), .Rin(Rin), .WAddr(WAddr), .R(R),
                  .set_0(set_0), .RAddrA(RAddrA), .RAddrB(RAddrB), .QA(qa1), .QB(qb1), .Written(w1));

  regfile_n #(.WIDTH(16), .DEPTH(6), .AW(3), .BYPASS(1'b1), .ZERO_REG(1'b1)) dut2 (.Clock(Clock),
                  .Resetn(Resetn), .Rin(Rin), .WAddr(WAddr), .R(R), .set_0(set_0), .RAddrA(RAddrA),
                  .RAddrB(RAddrB), .QA(qa2), .QB(qb2), .Written(w2));

  // Monitor: drain the scoreboard whenever the stimulus says outputs are settled.
  always @(posedge strobe) begin
    while (sb_q.size() > 0) begin
      exp_t        e;
      logic [15:0] aqa;
      logic [15:0] aqb;
      logic [7:0]  aw;
      e = sb_q.pop_front();
      case (e.d)
        0: begin aqa = qa0; aqb = qb0; aw = w0; end
        1: begin aqa = qa1; aqb = qb1; aw = w1; end
        default: begin aqa = qa2; aqb = qb2; aw = {2'b00, w2}; end
      endcase
      compared++;
      if (aqa !== e.qa || aqb !== e.qb || aw !== e.w) begin
        mismatched++;
        $display("FAIL %s dut%0d: got QA=%h QB=%h W=%b, expected QA=%h QB=%h W=%b",
                 e.name, e.d, aqa, aqb, aw, e.qa, e.qb, e.w);
      end
    end
  end

  task automatic push(input string n, input int d, input logic [15:0] qa, input logic [15:0] qb,
                      input logic [7:0] w);
    exp_t e;
    e.name = n; e.d = d; e.qa = qa; e.qb = qb; e.w = w;
    sb_q.push_back(e);
  endtask

  task automatic sample();
    strobe = 1'b1;
    #1 strobe = 1'b0;
    #1;
  endtask

  task automatic cyc_write(input logic [2:0] a, input logic [15:0] d);
    @(negedge Clock);
    Rin = 1'b1; WAddr = a; R = d;
    @(negedge Clock);
    Rin = 1'b0;
  endtask

  function automatic logic [15:0] fill_val(input int a);
    return 16'(16'h0101 * a);
  endfunction

  // DEPTH=6 zero-register instance only holds registers 1..5.
  function automatic logic [15:0] fill_val2(input int a);
    return (a >= 1 && a <= 5) ? fill_val(a) : 16'h0000;
  endfunction

  initial begin
    Resetn = 1'b0; Rin = 1'b0; set_0 = 1'b0; WAddr = 3'd0; R = 16'h0000;
    RAddrA = 3'd0; RAddrB = 3'd0;
    #2;
    for (int a = 0; a < 8; a++) begin
      RAddrA = 3'(a); RAddrB = 3'(7 - a);
      for (int d = 0; d < 3; d++) push("reset_read", d, 16'h0000, 16'h0000, 8'h00);
      sample();
    end
    @(negedge Clock);
    Resetn = 1'b1;

    cyc_write(3'd3, 16'hBEEF);
    RAddrA = 3'd3; RAddrB = 3'd3;
    #1;
    for (int d = 0; d < 3; d++) push("write_beef", d, 16'hBEEF, 16'hBEEF, 8'h08);
    sample();

    @(negedge Clock);
    Rin = 1'b1; WAddr = 3'd5; R = 16'h1234; RAddrA = 3'd5; RAddrB = 3'd3;
    #1;
    push("bypass_pre", 0, 16'h1234, 16'hBEEF, 8'h08);
    push("nobypass_pre", 1, 16'h0000, 16'hBEEF, 8'h08);
    push("bypass_pre", 2, 16'h1234, 16'hBEEF, 8'h08);
    sample();
    @(negedge Clock);
    Rin = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) push("bypass_post", d, 16'h1234, 16'hBEEF, 8'h28);
    sample();

    @(negedge Clock);
    Rin = 1'b1; WAddr = 3'd3; R = 16'h5555; RAddrA = 3'd3; RAddrB = 3'd5;
    #1;
    push("overwrite_pre", 0, 16'h5555, 16'h1234, 8'h28);
    push("overwrite_pre", 1, 16'hBEEF, 16'h1234, 8'h28);
    push("overwrite_pre", 2, 16'h5555, 16'h1234, 8'h28);
    sample();
    @(negedge Clock);
    Rin = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) push("overwrite_post", d, 16'h5555, 16'h1234, 8'h28);
    sample();

    for (int i = 0; i < 8; i++) cyc_write(3'(i), fill_val(i));
    for (int a = 0; a < 8; a++) begin
      RAddrA = 3'(a); RAddrB = 3'(7 - a);
      #1;
      push("fill", 0, fill_val(a), fill_val(7 - a), 8'hFF);
      push("fill", 1, fill_val(a), fill_val(7 - a), 8'hFF);
      push("fill", 2, fill_val2(a), fill_val2(7 - a), 8'h3E);
      sample();
    end

    @(negedge Clock);
    set_0 = 1'b1; Rin = 1'b1; WAddr = 3'd2; R = 16'hDEAD; RAddrA = 3'd2; RAddrB = 3'd6;
    #1;
    push("clear_pre", 0, 16'h0202, 16'h0606, 8'hFF);
    push("clear_pre", 1, 16'h0202, 16'h0606, 8'hFF);
    push("clear_pre", 2, 16'h0202, 16'h0000, 8'h3E);
    sample();
    @(negedge Clock);
    set_0 = 1'b0; Rin = 1'b0;
    for (int a = 0; a < 8; a++) begin
      RAddrA = 3'(a); RAddrB = 3'(7 - a);
      #1;
      for (int d = 0; d < 3; d++) push("clear_post", d, 16'h0000, 16'h0000, 8'h00);
      sample();
    end

    @(negedge Clock);
    Rin = 1'b1; WAddr = 3'd0; R = 16'hFFFF; RAddrA = 3'd0; RAddrB = 3'd1;
    #1;
    push("reg0_pre", 0, 16'hFFFF, 16'h0000, 8'h00);
    push("reg0_pre", 1, 16'h0000, 16'h0000, 8'h00);
    push("reg0_pre", 2, 16'h0000, 16'h0000, 8'h00);
    sample();
    @(negedge Clock);
    Rin = 1'b0;
    #1;
    push("reg0_post", 0, 16'hFFFF, 16'h0000, 8'h01);
    push("reg0_post", 1, 16'hFFFF, 16'h0000, 8'h01);
    push("reg0_post", 2, 16'h0000, 16'h0000, 8'h00);
    sample();

    @(negedge Clock);
    Rin = 1'b1; WAddr = 3'd7; R = 16'h7777; RAddrA = 3'd7; RAddrB = 3'd0;
    #1;
    push("addr7_pre", 0, 16'h7777, 16'hFFFF, 8'h01);
    push("addr7_pre", 1, 16'h0000, 16'hFFFF, 8'h01);
    push("addr7_pre", 2, 16'h0000, 16'h0000, 8'h00);
    sample();
    @(negedge Clock);
    Rin = 1'b0;
    #1;
    push("addr7_post", 0, 16'h7777, 16'hFFFF, 8'h81);
    push("addr7_post", 1, 16'h7777, 16'hFFFF, 8'h81);
    push("addr7_post", 2, 16'h0000, 16'h0000, 8'h00);
    sample();

    cyc_write(3'd4, 16'hAAAA);
    RAddrA = 3'd4; RAddrB = 3'd7;
    #1;
    push("pre_reset", 0, 16'hAAAA, 16'h7777, 8'h91);
    push("pre_reset", 1, 16'hAAAA, 16'h7777, 8'h91);
    push("pre_reset", 2, 16'hAAAA, 16'h0000, 8'h10);
    sample();
    Resetn = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) push("async_reset", d, 16'h0000, 16'h0000, 8'h00);
    sample();
    @(negedge Clock);
    Rin = 1'b1; set_0 = 1'b0; WAddr = 3'd1; R = 16'h1111; RAddrA = 3'd1; RAddrB = 3'd4;
    @(negedge Clock);
    Rin = 1'b0; Resetn = 1'b1;
    #1;
    for (int d = 0; d < 3; d++) push("write_in_reset", d, 16'h0000, 16'h0000, 8'h00);
    sample();

    cyc_write(3'd6, 16'h6666);
    RAddrA = 3'd6; RAddrB = 3'd4;
    #1;
    push("after_reset", 0, 16'h6666, 16'h0000, 8'h40);
    push("after_reset", 1, 16'h6666, 16'h0000, 8'h40);
    push("after_reset", 2, 16'h0000, 16'h0000, 8'h00);
    sample();

    #5;
    if (sb_q.size() != 0) begin
      mismatched++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/regfile_n.md
REGFILE_N -- requirements
Module: regfile_n

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, meaning data bits per register.
REQ-002 The block SHALL have parameter DEPTH, default 8, meaning the number of registers (2..256).
REQ-003 The block SHALL have parameter AW, default 3, meaning address width; AW SHALL equal ceil(log2(DEPTH)).
REQ-004 The block SHALL have parameter BYPASS, default 1, meaning 1 = write-through forwarding to the read ports, 0 = no forwarding.
REQ-005 The block SHALL have parameter ZERO_REG, default 0, meaning 1 = register 0 is hardwired to zero.
REQ-006 The block SHALL have port Clock, input, 1 bit: the single clock; all state changes on its rising edge except reset.
REQ-007 The block SHALL have port Resetn, input, 1 bit: asynchronous, active-low reset.
REQ-008 The block SHALL have port Rin, input, 1 bit: write enable.
REQ-009 The block SHALL have port WAddr, input, AW bits: write address.
REQ-010 The block SHALL have port R, input, WIDTH bits: write data.
REQ-011 The block SHALL have port set_0, input, 1 bit: synchronous clear of all registers.
REQ-012 The block SHALL have ports RAddrA and RAddrB, input, AW bits each: read addresses.
REQ-013 The block SHALL have ports QA and QB, output, WIDTH bits each: read data.
REQ-014 The block SHALL have port Written, output, DEPTH bits: bit i = 1 when register i has been written since the last reset or clear.

Function
REQ-015 On a rising Clock edge with Resetn=1, set_0=1, the block SHALL set every register and every Written bit to 0, regardless of Rin.
REQ-016 On a rising edge with set_0=0, Rin=1 and WAddr<DEPTH, the block SHALL load R into register WAddr and set Written[WAddr]=1; all other registers hold.
REQ-017 Writes with WAddr>=DEPTH SHALL be ignored, with no state change.
REQ-018 With Rin=0 and set_0=0, all registers and Written SHALL hold their values.
REQ-019 QA and QB SHALL be combinational functions of RAddrA/RAddrB and state, with zero-cycle read latency; both ports SHALL be independent and MAY address the same register.
REQ-020 A read with address>=DEPTH SHALL return 0.
REQ-021 With BYPASS=1, Rin=1, set_0=0 and a read address equal to an in-range WAddr, that port SHALL return R in the same cycle.
REQ-022 With BYPASS=0 in the case of REQ-021, the port SHALL return the stored (old) value; the new value SHALL be visible from the cycle after the edge.
REQ-023 While set_0=1, reads SHALL return the stored values, with no forwarding; zeros SHALL appear after the edge.
REQ-024 With ZERO_REG=1, register 0 SHALL always read 0 (including via bypass), writes to it SHALL be ignored, and Written[0] SHALL stay 0.
REQ-025 Write latency SHALL be exactly one edge: data written at edge k SHALL be readable from stored state immediately after edge k.

Reset
REQ-026 Resetn=0 SHALL immediately, without waiting for Clock, clear all registers and Written to 0; QA and QB then SHALL read 0.
REQ-027 While Resetn=0, Rin and set_0 SHALL have no effect.
REQ-028 A write coinciding with the edge on which Resetn deasserts SHALL be either taken or dropped consistently in implementation; the bench SHALL not depend on it.
REQ-029 Assertion of reset mid-operation SHALL discard all contents with no partial state retained.

Verification
REQ-030 Reset, then read all addresses -> QA=QB=0 and Written=0.
REQ-031 Write 0xBEEF to reg 3; next cycle RAddrA=3, RAddrB=3 -> QA=QB=0xBEEF and Written=8'b0000_1000.
REQ-032 BYPASS=1: Rin=1, WAddr=5, R=0x1234, RAddrA=5, before the edge -> QA=0x1234; with BYPASS=0 -> QA=old value.
REQ-033 Fill regs 0..7 with 0x0101*i, then set_0=1 together with Rin=1, WAddr=2 -> after the edge all reads are 0, Written=0, and the write is dropped.
REQ-034 ZERO_REG=1: write 0xFFFF to reg 0 -> QA(0)=0, Written[0]=0; DEPTH=6: write WAddr=7 -> no change, read addr 7 -> 0.
REQ-035 Write reg 4=0xAAAA, pulse Resetn low between clock edges -> QA(4)=0 immediately, before the next edge.
